divisor_result_fifo: RTL and testbench

Downstream stage of divisor_segmentado_top. Captures every quotient/remainder pair on the divider's done strobe into a FIFO and presents results to the consumer with a valid/ready handshake. Counts operations still in flight inside the divider pipeline. Issues a can_start credit so the upstream issuer never launches a division whose result could not be buffered.

---
 rtl/divisor_pkg.sv | 22 ++
 rtl/divisor_result_mem.sv | 36 +++
 rtl/divisor_result_fifo.sv | 155 +++++++++++++++
 tb/tb_divisor_result_fifo.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
// Shared types and sizing helpers for the divisor result path.
//   TAMANYO        : default quotient/remainder width
//   DEPTH_DEF      : default result FIFO depth
//   result_t       : {coc, res} payload captured from the divider
//   counter_width  : bits needed to hold 0..depth inclusive
package divisor_pkg;

    localparam int unsigned TAMANYO   = 8;
    localparam int unsigned DEPTH_DEF = 8;

    // The payload is sized by TAMANYO; instantiate the FIFO with a
    // matching tamanyo.
    typedef struct packed {
        logic [TAMANYO-1:0] coc;
        logic [TAMANYO-1:0] res;
    } result_t;

    function automatic int unsigned counter_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/divisor_result_mem.sv
// DEPTH x result_t register array: one synchronous write port, one
// asynchronous read port. The contents are not reset; the FIFO masks
// the read data whenever it is empty.
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write payload
//   raddr_i  : read address
//   rdata_o  : read payload (combinational)
module divisor_result_mem
    import divisor_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  result_t       wdata_i,
    input  logic [AW-1:0] raddr_i,
    output result_t       rdata_o
);

    result_t mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read port
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/divisor_result_fifo.sv
// Result buffer behind the pipelined divider. Captures {coc,res} on every
// done_in strobe, presents the head entry first-word-fall-through with a
// valid/ready handshake, tracks divisions still inside the pipeline and
// grants can_start only while every launched result is guaranteed a slot.
// Optional feature macro: RESULT_FIFO_STATS_EN (results_total, max_count).
//   clk, rst_n        : clock, synchronous active-low reset
//   start_in          : START issued to the divider this cycle
//   done_in           : divider DONE; coc_in/res_in valid
//   coc_in, res_in    : quotient / remainder from divider
//   can_start         : issuer may assert start next cycle
//   valid_out         : head entry available
//   ready_in          : consumer accepts head entry
//   coc_out, res_out  : head quotient / remainder (0 when empty)
//   count_out         : entries stored
//   err               : sticky protocol / overflow error
module divisor_result_fifo
    import divisor_pkg::*;
#(
    parameter int unsigned tamanyo = TAMANYO,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned CW      = counter_width(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_in,
    input  logic               done_in,
    input  logic [tamanyo-1:0] coc_in,
    input  logic [tamanyo-1:0] res_in,
    output logic               can_start,
    output logic               valid_out,
    input  logic               ready_in,
    output logic [tamanyo-1:0] coc_out,
    output logic [tamanyo-1:0] res_out,
    output logic [CW-1:0]      count_out,
    output logic               err
`ifdef RESULT_FIFO_STATS_EN
    ,
    output logic [31:0]        results_total,
    output logic [CW-1:0]      max_count
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW = CW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic          err_q, err_d;

    logic    push;
    logic    pop;
    logic    full;
    logic    wr_en;
    result_t wdata;
    result_t rdata;

    assign push  = done_in;
    assign pop   = valid_out & ready_in;
    assign full  = (count_q == CW'(DEPTH));
    // A push into a full FIFO is only kept when the head leaves the same cycle.
    assign wr_en = push & (~full | pop);

    assign wdata.coc = coc_in;
    assign wdata.res = res_in;

    divisor_result_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    // Outputs derived from registered state only
    assign valid_out = (count_q != '0);
    assign coc_out   = valid_out ? rdata.coc : '0;
    assign res_out   = valid_out ? rdata.res : '0;
    assign count_out = count_q;
    assign err       = err_q;
    // Credit ignores a same-cycle pop, so it can only under-grant.
    assign can_start = (SW'(count_q) + SW'(inflight_q)) < SW'(DEPTH);

    // Next-state for pointers, counters and error flag
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        err_d      = err_q;

        // DEPTH is a power of two, so pointers wrap naturally.
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);

        if (wr_en && !pop)      count_d = count_q + CW'(1);
        else if (pop && !wr_en) count_d = count_q - CW'(1);

        if (start_in && !done_in)      inflight_d = inflight_q + CW'(1);
        else if (done_in && !start_in) inflight_d = inflight_q - CW'(1);

        if (start_in && !can_start)         err_d = 1'b1;
        if (done_in && (inflight_q == '0))  err_d = 1'b1;
        if (push && !wr_en)                 err_d = 1'b1;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

`ifdef RESULT_FIFO_STATS_EN
    logic [31:0]   results_total_q, results_total_d;
    logic [CW-1:0] max_count_q, max_count_d;

    // Pop counter and occupancy high-water mark
    always_comb begin
        results_total_d = results_total_q;
        max_count_d     = max_count_q;
        if (pop) results_total_d = results_total_q + 32'd1;
        if (count_d > max_count_q) max_count_d = count_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            results_total_q <= '0;
            max_count_q     <= '0;
        end else begin
            results_total_q <= results_total_d;
            max_count_q     <= max_count_d;
        end
    end

    assign results_total = results_total_q;
    assign max_count     = max_count_q;
`endif

endmodule

// File: tb/tb_divisor_result_fifo.sv
// Directed bench for divisor_result_fifo: reset, single op, fill/drain
// ordering, overflow drop, full push+pop, and protocol errors.
module tb_divisor_result_fifo;
    import divisor_pkg::*;

    localparam int unsigned TW = 8;
    localparam int unsigned DP = 8;
    localparam int unsigned CWT = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start_in;
    logic           done_in;
    logic [TW-1:0]  coc_in;
    logic [TW-1:0]  res_in;
    logic           can_start;
    logic           valid_out;
    logic           ready_in;
    logic [TW-1:0]  coc_out;
    logic [TW-1:0]  res_out;
    logic [CWT-1:0] count_out;
    logic           err;
`ifdef RESULT_FIFO_STATS_EN
    logic [31:0]    results_total;
    logic [CWT-1:0] max_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    divisor_result_fifo #(
        .tamanyo (TW),
        .DEPTH   (DP),
        .CW      (CWT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_in  (start_in),
        .done_in   (done_in),
        .coc_in    (coc_in),
        .res_in    (res_in),
        .can_start (can_start),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .coc_out   (coc_out),
        .res_out   (res_out),
        .count_out (count_out),
        .err       (err)
`ifdef RESULT_FIFO_STATS_EN
        ,
        .results_total (results_total),
        .max_count     (max_count)
`endif
    );

    // Advance one edge and settle 1ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        start_in = 1'b0;
        done_in  = 1'b0;
        ready_in = 1'b0;
        coc_in   = '0;
        res_in   = '0;
        rst_n    = 1'b0;
        tick();
        rst_n    = 1'b1;
    endtask

    // Eight legal starts then eight dones carrying {base+k, k}
    task automatic fill8(input logic [7:0] base);
        ready_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            start_in = 1'b1;
            tick();
        end
        start_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            done_in = 1'b1;
            coc_in  = base + 8'(k);
            res_in  = 8'(k);
            tick();
        end
        done_in = 1'b0;
    endtask

    initial begin
        // Reset then idle
        do_reset();
        tick();
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_can_start", 32'(can_start), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_coc", 32'(coc_out), 32'd0);
        chk("rst_res", 32'(res_out), 32'd0);

        // Single operation 100/7 = 14 r 2
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        tick();
        done_in  = 1'b1;
        coc_in   = 8'd14;
        res_in   = 8'd2;
        ready_in = 1'b1;
        chk("single_no_bypass", 32'(valid_out), 32'd0);
        tick();
        done_in = 1'b0;
        chk("single_valid", 32'(valid_out), 32'd1);
        chk("single_coc", 32'(coc_out), 32'd14);
        chk("single_res", 32'(res_out), 32'd2);
        chk("single_count1", 32'(count_out), 32'd1);
        tick();
        ready_in = 1'b0;
        chk("single_count0", 32'(count_out), 32'd0);
        chk("single_empty", 32'(valid_out), 32'd0);
        chk("single_err", 32'(err), 32'd0);

        // Eight back-to-back starts, results i/3 for i=10..17, then drain
        ready_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("burst_credit_open", 32'(can_start), 32'd1);
            start_in = 1'b1;
            tick();
        end
        start_in = 1'b0;
        chk("burst_credit_closed", 32'(can_start), 32'd0);
        for (int i = 10; i <= 17; i++) begin
            done_in = 1'b1;
            coc_in  = 8'(i / 3);
            res_in  = 8'(i % 3);
            tick();
        end
        done_in = 1'b0;
        chk("burst_count8", 32'(count_out), 32'd8);
        chk("burst_full_credit", 32'(can_start), 32'd0);
        chk("burst_err", 32'(err), 32'd0);
        ready_in = 1'b1;
        for (int i = 10; i <= 17; i++) begin
            chk("drain_valid", 32'(valid_out), 32'd1);
            chk("drain_coc", 32'(coc_out), 32'(i / 3));
            chk("drain_res", 32'(res_out), 32'(i % 3));
            tick();
        end
        ready_in = 1'b0;
        chk("drain_count0", 32'(count_out), 32'd0);
        chk("drain_empty", 32'(valid_out), 32'd0);
        chk("drain_credit", 32'(can_start), 32'd1);

        // Overflow: push into full FIFO without pop is dropped
        fill8(8'h40);
        done_in = 1'b1;
        coc_in  = 8'hAA;
        res_in  = 8'h55;
        tick();
        done_in = 1'b0;
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_count", 32'(count_out), 32'd8);
        chk("ovf_head_coc", 32'(coc_out), 32'h40);
        chk("ovf_head_res", 32'(res_out), 32'h00);
        tick();
        chk("ovf_err_sticky", 32'(err), 32'd1);
        do_reset();
        chk("ovf_rst_err", 32'(err), 32'd0);
        chk("ovf_rst_count", 32'(count_out), 32'd0);
        chk("ovf_rst_valid", 32'(valid_out), 32'd0);
        chk("ovf_rst_credit", 32'(can_start), 32'd1);

        // Full FIFO: push and pop in the same cycle
        fill8(8'h60);
        done_in  = 1'b1;
        coc_in   = 8'h77;
        res_in   = 8'h09;
        ready_in = 1'b1;
        tick();
        done_in  = 1'b0;
        ready_in = 1'b0;
        chk("fullpp_count", 32'(count_out), 32'd8);
        // Full implies nothing in flight, so that DONE is itself a protocol error
        chk("fullpp_err_no_inflight", 32'(err), 32'd1);
        ready_in = 1'b1;
        for (int k = 1; k < 8; k++) begin
            chk("fullpp_drain_coc", 32'(coc_out), 32'h60 + 32'(k));
            chk("fullpp_drain_res", 32'(res_out), 32'(k));
            tick();
        end
        chk("fullpp_last_coc", 32'(coc_out), 32'h77);
        chk("fullpp_last_res", 32'(res_out), 32'h09);
        tick();
        ready_in = 1'b0;
        chk("fullpp_count0", 32'(count_out), 32'd0);
        do_reset();

        // DONE with nothing in flight
        chk("noinflight_pre_err", 32'(err), 32'd0);
        done_in = 1'b1;
        coc_in  = 8'd1;
        res_in  = 8'd1;
        tick();
        done_in = 1'b0;
        chk("noinflight_err", 32'(err), 32'd1);
        do_reset();
        chk("noinflight_rst_err", 32'(err), 32'd0);

        // START while credit is closed
        for (int k = 0; k < 8; k++) begin
            start_in = 1'b1;
            tick();
        end
        start_in = 1'b0;
        chk("nocredit_closed", 32'(can_start), 32'd0);
        chk("nocredit_pre_err", 32'(err), 32'd0);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        chk("nocredit_err", 32'(err), 32'd1);
        do_reset();
        tick();
        chk("final_err", 32'(err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
